// File: rtl/lc3b_types.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lc3b_types : shared widths, line/word types and arbiter state enum   |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package lc3b_types;

  localparam int LC3B_WORD_W = 16;
  localparam int LC3B_LINE_W = 128;

  typedef logic [LC3B_WORD_W-1:0] lc3b_word;
  typedef logic [LC3B_LINE_W-1:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } cache_arb_state;

endpackage
`default_nettype wire

// File: rtl/cache_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_arbiter_if : I-cache, D-cache and L2 buses around the arbiter  |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
interface cache_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  logic                  i_pmem_read;
  logic [ADDR_WIDTH-1:0] i_pmem_address;
  logic                  i_pmem_resp;
  logic [LINE_WIDTH-1:0] i_pmem_rdata;

  logic                  d_pmem_read;
  logic                  d_pmem_write;
  logic [ADDR_WIDTH-1:0] d_pmem_address;
  logic [LINE_WIDTH-1:0] d_pmem_wdata;
  logic                  d_pmem_resp;
  logic [LINE_WIDTH-1:0] d_pmem_rdata;

  logic                  l2_read;
  logic                  l2_write;
  logic [ADDR_WIDTH-1:0] l2_address;
  logic [LINE_WIDTH-1:0] l2_wdata;
  logic [LINE_WIDTH-1:0] l2_rdata;
  logic                  l2_resp;

  logic [15:0]           conflict_count;
  logic                  last_grant;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_resp, i_pmem_rdata,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_resp, d_pmem_rdata,
    output l2_read, l2_write, l2_address, l2_wdata,
    input  l2_rdata, l2_resp,
    output conflict_count, last_grant
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_resp, i_pmem_rdata,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_resp, d_pmem_rdata,
    input  l2_read, l2_write, l2_address, l2_wdata,
    output l2_rdata, l2_resp,
    input  conflict_count, last_grant
  );
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter : 16-bit up-counter, saturates at all-ones, sync clear   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module sat_counter (
  input  wire logic        clk,
  input  wire logic        i_clr,
  input  wire logic        i_en,
  output logic [15:0]      o_count
);

  logic [15:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= 16'd0;
    end else if (i_en && !(&r_count)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_arbiter : round-robin I/D cache arbitration onto a shared L2   |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = LC3B_WORD_W,
  parameter int LINE_WIDTH = LC3B_LINE_W
) (
  input  wire logic       clk,
  input  wire logic       rst,
  cache_arbiter_if.slave  bus
);

  cache_arb_state        r_state;
  logic                  r_last_grant;

  logic                  w_i_req;
  logic                  w_d_req;
  logic                  w_conflict;
  logic                  w_l2_read;
  logic                  w_l2_write;
  logic                  w_i_resp;
  logic                  w_d_resp;
  logic [ADDR_WIDTH-1:0] w_l2_address;
  logic [LINE_WIDTH-1:0] w_l2_wdata;
  logic [15:0]           w_count;

  assign w_i_req = bus.i_pmem_read;
  assign w_d_req = bus.d_pmem_read | bus.d_pmem_write;

  // On a tie the side that was not served last wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_i_req && (!w_d_req || r_last_grant)) begin
            r_state      <= SERVE_I;
            r_last_grant <= 1'b0;
          end else if (w_d_req) begin
            r_state      <= SERVE_D;
            r_last_grant <= 1'b1;
          end
        end
        SERVE_I, SERVE_D: begin
          if (bus.l2_resp) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_l2_read    = 1'b0;
    w_l2_write   = 1'b0;
    w_l2_address = '0;
    w_l2_wdata   = '0;
    w_i_resp     = 1'b0;
    w_d_resp     = 1'b0;
    w_conflict   = 1'b0;
    case (r_state)
      SERVE_I: begin
        w_l2_read    = 1'b1;
        w_l2_address = bus.i_pmem_address;
        w_i_resp     = bus.l2_resp;
        w_conflict   = w_d_req;
      end
      SERVE_D: begin
        w_l2_write   = bus.d_pmem_write;
        w_l2_read    = !bus.d_pmem_write;
        w_l2_address = bus.d_pmem_address;
        w_l2_wdata   = bus.d_pmem_wdata;
        w_d_resp     = bus.l2_resp;
        w_conflict   = w_i_req;
      end
      default: ;
    endcase
  end

  sat_counter u_conflict_cnt (
    .clk     (clk),
    .i_clr   (rst),
    .i_en    (w_conflict),
    .o_count (w_count)
  );

  assign bus.l2_read        = w_l2_read;
  assign bus.l2_write       = w_l2_write;
  assign bus.l2_address     = w_l2_address;
  assign bus.l2_wdata       = w_l2_wdata;
  assign bus.i_pmem_resp    = w_i_resp;
  assign bus.d_pmem_resp    = w_d_resp;
  assign bus.i_pmem_rdata   = bus.l2_rdata;
  assign bus.d_pmem_rdata   = bus.l2_rdata;
  assign bus.conflict_count = w_count;
  assign bus.last_grant     = r_last_grant;

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cache_arbiter : directed self-checking bench for cache_arbiter    |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module tb_cache_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  cache_arbiter_if #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) bus ();

  cache_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst                = 1'b1;
    bus.i_pmem_read    = 1'b0;
    bus.i_pmem_address = '0;
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_address = '0;
    bus.d_pmem_wdata   = '0;
    bus.l2_rdata       = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    bus.l2_resp        = 1'b0;

    // Reset state
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_l2_read",  bus.l2_read, 0);
    check("rst_l2_write", bus.l2_write, 0);
    check("rst_conflict", bus.conflict_count, 0);
    check("rst_last",     bus.last_grant, 1);
    check("rst_i_rdata",  bus.i_pmem_rdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    check("rst_d_rdata",  bus.d_pmem_rdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);

    // Single I-side fill, L2 answers on the third grant cycle
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 16'h1230;
    #1 check("t1_req_cycle_idle", bus.l2_read, 0);
    step();
    check("t1_l2_read", bus.l2_read, 1);
    check("t1_l2_addr", bus.l2_address, 16'h1230);
    check("t1_i_resp_early", bus.i_pmem_resp, 0);
    step(); step();
    check("t1_l2_read_held", bus.l2_read, 1);
    bus.l2_resp = 1'b1;
    #1;
    check("t1_i_resp", bus.i_pmem_resp, 1);
    check("t1_d_resp", bus.d_pmem_resp, 0);
    step();
    bus.i_pmem_read = 1'b0;
    bus.l2_resp     = 1'b0;
    #1;
    check("t1_idle_read", bus.l2_read, 0);
    check("t1_last", bus.last_grant, 0);

    // Simultaneous I and D reads after reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 16'h1230;
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 16'h2340;
    step();
    check("t2_first_addr", bus.l2_address, 16'h1230);
    check("t2_first_last", bus.last_grant, 0);
    step(); step();
    bus.l2_resp = 1'b1;
    #1;
    check("t2_i_resp", bus.i_pmem_resp, 1);
    check("t2_d_resp_hold", bus.d_pmem_resp, 0);
    step();
    bus.i_pmem_read = 1'b0;
    bus.l2_resp     = 1'b0;
    #1;
    check("t2_gap_read", bus.l2_read, 0);
    check("t2_conflict", bus.conflict_count, 3);
    step();
    check("t2_second_read", bus.l2_read, 1);
    check("t2_second_addr", bus.l2_address, 16'h2340);
    check("t2_second_last", bus.last_grant, 1);
    bus.l2_resp = 1'b1;
    #1;
    check("t2_d_resp", bus.d_pmem_resp, 1);
    check("t2_i_resp_hold", bus.i_pmem_resp, 0);
    step();
    bus.d_pmem_read = 1'b0;
    bus.l2_resp     = 1'b0;
    #1;
    check("t2_conflict_end", bus.conflict_count, 3);

    // D-side writeback with read also asserted: write wins
    bus.d_pmem_write   = 1'b1;
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 16'h4000;
    bus.d_pmem_wdata   = {16{8'hA5}};
    step();
    check("t3_l2_write", bus.l2_write, 1);
    check("t3_l2_read",  bus.l2_read, 0);
    check("t3_l2_addr",  bus.l2_address, 16'h4000);
    check("t3_l2_wdata", bus.l2_wdata, {16{8'hA5}});
    bus.l2_resp = 1'b1;
    #1;
    check("t3_d_resp", bus.d_pmem_resp, 1);
    step();
    bus.d_pmem_write = 1'b0;
    bus.d_pmem_read  = 1'b0;
    bus.l2_resp      = 1'b0;
    #1;
    check("t3_idle_write", bus.l2_write, 0);

    // Continuous contention: grants alternate with one IDLE cycle between
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 16'h1111;
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 16'h2222;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("t4_read_%0d", k), bus.l2_read, 1);
      check($sformatf("t4_addr_%0d", k), bus.l2_address, (k % 2 == 0) ? 16'h1111 : 16'h2222);
      bus.l2_resp = 1'b1;
      #1;
      if (k % 2 == 0) check($sformatf("t4_i_resp_%0d", k), bus.i_pmem_resp, 1);
      else            check($sformatf("t4_d_resp_%0d", k), bus.d_pmem_resp, 1);
      step();
      check($sformatf("t4_gap_read_%0d", k), bus.l2_read, 0);
      check($sformatf("t4_gap_resp_%0d", k), {bus.i_pmem_resp, bus.d_pmem_resp}, 0);
      bus.l2_resp = 1'b0;
    end
    check("t4_conflict", bus.conflict_count, 6);

    // Reset in the middle of a D-side transaction
    bus.i_pmem_read = 1'b0;
    step();
    check("t5_serve_d", bus.l2_address, 16'h2222);
    rst = 1'b1;
    bus.d_pmem_read = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check("t5_read",     bus.l2_read, 0);
    check("t5_write",    bus.l2_write, 0);
    check("t5_conflict", bus.conflict_count, 0);
    check("t5_last",     bus.last_grant, 1);
    bus.l2_resp = 1'b1;
    #1;
    check("t5_late_resp", {bus.i_pmem_resp, bus.d_pmem_resp}, 0);
    step();
    check("t5_still_idle", bus.l2_read, 0);
    bus.l2_resp = 1'b0;

    // Long contention to drive the counter into saturation
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 16'h1230;
    bus.d_pmem_read    = 1'b1;
    step();
    check("t6_start", bus.conflict_count, 0);
    repeat (65533) @(posedge clk);
    step();
    check("t6_fffe", bus.conflict_count, 16'hFFFE);
    step();
    check("t6_ffff", bus.conflict_count, 16'hFFFF);
    bus.i_pmem_read = 1'b0;
    step(); step();
    check("t6_hold_sat",  bus.conflict_count, 16'hFFFF);
    check("t6_hold_read", bus.l2_read, 1);
    check("t6_hold_addr", bus.l2_address, 16'h1230);
    check("t6_no_resp",   bus.i_pmem_resp, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
